neuron_accumulator: RTL

Downstream consumer of the Q-format fixed-point multiplier in the MLP datapath. Accepts a stream of signed products (weight × activation, already shifted back to `bits` width with `fractional_bits` fraction bits) for one neuron. It accumulates them onto a bias in a widened register, saturates back to `bits`, optionally applies ReLU, and presents one result per neuron over a valid/ready handshake.

---
 rtl/neuron_accumulator.sv | 123 ++++++++++++
 1 files changed

// File: rtl/neuron_accumulator.sv
// Single-neuron accumulator: sums a fixed number of signed Q-format products
// onto a bias in a widened register, saturates back to the data width,
// optionally applies ReLU and hands the result over a valid/ready handshake.
module neuron_accumulator #(
    parameter int bits            = 16,
    parameter int fractional_bits = 11,
    parameter int num_inputs      = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [bits-1:0] bias,
    input  logic            relu_en,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [bits-1:0] product,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [bits-1:0] result,
    output logic            overflow,
    output logic            busy
);

    localparam int CW  = $clog2(num_inputs);
    localparam int ACC = bits + CW + 1;

    localparam logic [CW-1:0]         LAST    = CW'(num_inputs - 1);
    localparam logic signed [ACC-1:0] SAT_MAX = {{(ACC-bits+1){1'b0}}, {(bits-1){1'b1}}};
    localparam logic signed [ACC-1:0] SAT_MIN = {{(ACC-bits+1){1'b1}}, {(bits-1){1'b0}}};

    // Bias, products and result all share one Q format, so no rescaling is done here;
    // the fraction width only has to fit inside the word.
    if (num_inputs < 2 || fractional_bits >= bits) begin : g_cfg_check
        $error("neuron_accumulator: needs num_inputs >= 2 and fractional_bits < bits");
    end

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FINAL,
        OUTPUT
    } state_t;

    state_t                  state_q;
    logic signed [ACC-1:0]   acc_q;
    logic [CW-1:0]           cnt_q;
    logic                    relu_q;
    logic [bits-1:0]         result_q;
    logic                    ovf_q;
    logic                    out_valid_q;

    logic [bits-1:0]         result_d;
    logic                    ovf_d;

    // Saturate the wide sum back to the word width, then apply the optional ReLU.
    always_comb begin
        result_d = acc_q[bits-1:0];
        ovf_d    = 1'b0;
        if (acc_q > SAT_MAX) begin
            result_d = SAT_MAX[bits-1:0];
            ovf_d    = 1'b1;
        end else if (acc_q < SAT_MIN) begin
            result_d = SAT_MIN[bits-1:0];
            ovf_d    = 1'b1;
        end
        if (relu_q && result_d[bits-1]) begin
            result_d = '0;
        end
    end

    // Control FSM with accumulator, beat counter and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            relu_q      <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q   <= {{(ACC-bits){bias[bits-1]}}, bias};
                        cnt_q   <= '0;
                        relu_q  <= relu_en;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_q <= acc_q + {{(ACC-bits){product[bits-1]}}, product};
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST) begin
                            state_q <= FINAL;
                        end
                    end
                end
                FINAL: begin
                    result_q    <= result_d;
                    ovf_q       <= ovf_d;
                    out_valid_q <= 1'b1;
                    state_q     <= OUTPUT;
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = ovf_q;

endmodule
